// File: rtl/soc_estimator_mc.sv
// soc_estimator_mc: multi-channel hybrid state-of-charge estimator.
// A single time-multiplexed datapath walks every cell on each tick. It combines
// an ESR-compensated voltage lookup with clamped coulomb counting. Voltage is
// trusted again only after the cell has rested for a programmable dwell.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for the next tick
// SNAP   | capture all voltage/current inputs so the pass sees one instant
// LOAD   | ESR compensation and rest detection for channel ch
// CALC   | voltage-derived SoC and clamped coulomb-count candidate
// UPDATE | commit seed / rest recalibration / coulomb result for channel ch
// DONE   | one-cycle soc_valid, pass complete

module soc_estimator_mc #(
   parameter int NUM_CH     = 4,
   parameter int V_W        = 16,
   parameter int I_W        = 16,
   parameter int SOC_W      = 8,
   parameter int Q_W        = 32,
   parameter int CLK_DIV    = 50000,
   parameter int V_MAX      = 65535,
   parameter int V_MIN      = 0,
   parameter int Q_FULL     = 1400000,
   parameter int I_SCALE    = 100,
   parameter int ESR        = 1000,
   parameter int ESR_DIV    = 1000,
   parameter int I_THRESH   = 5,
   parameter int REST_TICKS = 1000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_CH*V_W-1:0]     voltage,
   input  logic [NUM_CH*I_W-1:0]     current,
   output logic [NUM_CH*SOC_W-1:0]   soc,
   output logic [NUM_CH-1:0]         soc_mode,
   output logic                      soc_valid,
   output logic                      busy,
   output logic                      overrun
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int RC_W  = $clog2(REST_TICKS + 1);

   // All datapath arithmetic is done in 64-bit signed so products never wrap.
   localparam logic signed [63:0] V_TOP     = (64'sd1 <<< V_W) - 64'sd1;
   localparam logic signed [63:0] ESR_L     = 64'(ESR);
   localparam logic signed [63:0] ESR_DIV_L = 64'(ESR_DIV);
   localparam logic signed [63:0] V_MAX_L   = 64'(V_MAX);
   localparam logic signed [63:0] V_MIN_L   = 64'(V_MIN);
   localparam logic signed [63:0] Q_FULL_L  = 64'(Q_FULL);
   localparam logic signed [63:0] I_SCALE_L = 64'(I_SCALE);
   localparam logic signed [63:0] I_TH_L    = 64'(I_THRESH);
   localparam logic signed [63:0] HUNDRED   = 64'sd100;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SNAP,
      S_LOAD,
      S_CALC,
      S_UPDATE,
      S_DONE
   } state_t;

   state_t                    state_q, state_d;
   logic [CH_W-1:0]           ch_q, ch_d;
   logic [DIV_W-1:0]          div_q, div_d;
   logic                      overrun_q, overrun_d;
   logic                      tick;
   logic                      last_ch;

   logic [NUM_CH*V_W-1:0]     v_snap_q, v_snap_d;
   logic [NUM_CH*I_W-1:0]     i_snap_q, i_snap_d;
   logic [V_W-1:0]            vcomp_q, vcomp_d;
   logic                      resting_q, resting_d;
   logic [SOC_W-1:0]          socv_q, socv_d;
   logic [Q_W-1:0]            qnext_q, qnext_d;

   logic [Q_W-1:0]            q_q [NUM_CH];
   logic [Q_W-1:0]            q_d [NUM_CH];
   logic [RC_W-1:0]           rest_q [NUM_CH];
   logic [RC_W-1:0]           rest_d [NUM_CH];
   logic [NUM_CH-1:0]         seeded_q, seeded_d;
   logic [NUM_CH*SOC_W-1:0]   soc_q, soc_d;
   logic [NUM_CH-1:0]         mode_q, mode_d;

   logic [V_W-1:0]            v_cur;
   logic [I_W-1:0]            i_cur;
   logic [Q_W-1:0]            q_cur;
   logic [RC_W-1:0]           rest_cur;
   logic [RC_W:0]             rc_inc;
   logic signed [63:0]        v_s, i_s, q_s, v_c, vc_s, socv_w, sum_s;
   logic signed [63:0]        sv_s, seed_w, qn_s, socq_w;

   assign tick    = (div_q == DIV_W'(CLK_DIV - 1));
   assign last_ch = (ch_q == CH_W'(NUM_CH - 1));

   // Tick divider free-runs 0..CLK_DIV-1 independent of the FSM.
   always_comb begin
      div_d = tick ? '0 : div_q + 1'b1;
   end

   // Sequencer: next state, channel index and sticky overrun.
   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      overrun_d = overrun_q | (tick && (state_q != S_IDLE));
      case (state_q)
         S_IDLE: begin
            if (tick) state_d = S_SNAP;
         end
         S_SNAP: begin
            state_d = S_LOAD;
            ch_d    = '0;
         end
         S_LOAD:   state_d = S_CALC;
         S_CALC:   state_d = S_UPDATE;
         S_UPDATE: begin
            if (last_ch) begin
               state_d = S_DONE;
            end else begin
               state_d = S_LOAD;
               ch_d    = ch_q + 1'b1;
            end
         end
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Shared datapath: one channel per LOAD/CALC/UPDATE triple.
   always_comb begin
      v_snap_d  = v_snap_q;
      i_snap_d  = i_snap_q;
      vcomp_d   = vcomp_q;
      resting_d = resting_q;
      socv_d    = socv_q;
      qnext_d   = qnext_q;
      q_d       = q_q;
      rest_d    = rest_q;
      seeded_d  = seeded_q;
      soc_d     = soc_q;
      mode_d    = mode_q;

      v_cur    = v_snap_q[int'(ch_q)*V_W +: V_W];
      i_cur    = i_snap_q[int'(ch_q)*I_W +: I_W];
      q_cur    = q_q[ch_q];
      rest_cur = rest_q[ch_q];
      rc_inc   = {1'b0, rest_cur} + 1'b1;

      v_s    = $signed({{(64-V_W){1'b0}}, v_cur});
      i_s    = $signed({{(64-I_W){i_cur[I_W-1]}}, i_cur});
      q_s    = $signed({{(64-Q_W){q_cur[Q_W-1]}}, q_cur});
      vc_s   = $signed({{(64-V_W){1'b0}}, vcomp_q});
      sv_s   = $signed({{(64-SOC_W){1'b0}}, socv_q});
      qn_s   = $signed({{(64-Q_W){qnext_q[Q_W-1]}}, qnext_q});
      v_c    = v_s - (i_s * ESR_L) / ESR_DIV_L;
      sum_s  = q_s + i_s * I_SCALE_L;
      seed_w = (sv_s * Q_FULL_L) / HUNDRED;
      socq_w = (qn_s * HUNDRED) / Q_FULL_L;

      if (vc_s >= V_MAX_L)      socv_w = HUNDRED;
      else if (vc_s <= V_MIN_L) socv_w = '0;
      else                      socv_w = ((vc_s - V_MIN_L) * HUNDRED) / (V_MAX_L - V_MIN_L);

      case (state_q)
         S_SNAP: begin
            v_snap_d = voltage;
            i_snap_d = current;
         end
         S_LOAD: begin
            if (v_c < 0)          vcomp_d = '0;
            else if (v_c > V_TOP) vcomp_d = '1;
            else                  vcomp_d = V_W'(v_c);
            resting_d = (i_s > -I_TH_L) && (i_s < I_TH_L);
         end
         S_CALC: begin
            socv_d = SOC_W'(socv_w);
            if (sum_s < 0)             qnext_d = '0;
            else if (sum_s > Q_FULL_L) qnext_d = Q_W'(Q_FULL_L);
            else                       qnext_d = Q_W'(sum_s);
         end
         S_UPDATE: begin
            if (!seeded_q[ch_q]) begin
               q_d[ch_q]                         = Q_W'(seed_w);
               seeded_d[ch_q]                    = 1'b1;
               rest_d[ch_q]                      = '0;
               soc_d[int'(ch_q)*SOC_W +: SOC_W]  = socv_q;
               mode_d[ch_q]                      = 1'b1;
            end else if (resting_q) begin
               // Recalibrate once, on the tick the dwell is reached.
               if (rest_cur != RC_W'(REST_TICKS)) begin
                  rest_d[ch_q] = RC_W'(rc_inc);
                  if (rc_inc == (RC_W+1)'(REST_TICKS)) begin
                     q_d[ch_q]                        = Q_W'(seed_w);
                     soc_d[int'(ch_q)*SOC_W +: SOC_W] = socv_q;
                     mode_d[ch_q]                     = 1'b1;
                  end
               end
            end else begin
               rest_d[ch_q]                      = '0;
               q_d[ch_q]                         = qnext_q;
               soc_d[int'(ch_q)*SOC_W +: SOC_W]  = SOC_W'(socq_w);
               mode_d[ch_q]                      = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ch_q      <= '0;
         div_q     <= '0;
         overrun_q <= 1'b0;
         v_snap_q  <= '0;
         i_snap_q  <= '0;
         vcomp_q   <= '0;
         resting_q <= 1'b0;
         socv_q    <= '0;
         qnext_q   <= '0;
         seeded_q  <= '0;
         soc_q     <= '0;
         mode_q    <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            q_q[k]    <= '0;
            rest_q[k] <= '0;
         end
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         div_q     <= div_d;
         overrun_q <= overrun_d;
         v_snap_q  <= v_snap_d;
         i_snap_q  <= i_snap_d;
         vcomp_q   <= vcomp_d;
         resting_q <= resting_d;
         socv_q    <= socv_d;
         qnext_q   <= qnext_d;
         seeded_q  <= seeded_d;
         soc_q     <= soc_d;
         mode_q    <= mode_d;
         for (int k = 0; k < NUM_CH; k++) begin
            q_q[k]    <= q_d[k];
            rest_q[k] <= rest_d[k];
         end
      end
   end

   assign soc       = soc_q;
   assign soc_mode  = mode_q;
   assign soc_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_soc_estimator_mc.sv
// Scoreboard bench for soc_estimator_mc: stimulus pushes expected per-pass
// results from a behavioural model; a monitor pops them on soc_valid.

module tb_soc_estimator_mc;

   localparam int NCH     = 2;
   localparam int CLK_DIV = 20;
   localparam int Q_FULL  = 10000;
   localparam int REST    = 3;
   localparam int LAT     = 3*NCH + 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NCH*16-1:0] voltage = '0;
   logic [NCH*16-1:0] current = '0;
   logic [NCH*8-1:0] soc, soc2;
   logic [NCH-1:0]   soc_mode, soc_mode2;
   logic             soc_valid, busy, overrun;
   logic             soc_valid2, busy2, overrun2;

   soc_estimator_mc #(.NUM_CH(NCH), .CLK_DIV(CLK_DIV), .Q_FULL(Q_FULL), .REST_TICKS(REST)) dut (
      .clk(clk), .rst_n(rst_n), .voltage(voltage), .current(current),
      .soc(soc), .soc_mode(soc_mode), .soc_valid(soc_valid), .busy(busy), .overrun(overrun)
   );

   soc_estimator_mc #(.NUM_CH(NCH), .CLK_DIV(5), .Q_FULL(Q_FULL), .REST_TICKS(REST)) dut_fast (
      .clk(clk), .rst_n(rst_n), .voltage(voltage), .current(current),
      .soc(soc2), .soc_mode(soc_mode2), .soc_valid(soc_valid2), .busy(busy2), .overrun(overrun2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   typedef struct {
      logic [NCH*8-1:0] soc;
      logic [NCH-1:0]   mode;
      int               cyc;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: per-cell charge, rest dwell, seeded flag, outputs.
   longint mq[NCH];
   int     mrest[NCH];
   bit     mseed[NCH];
   int     msoc[NCH];
   bit     mmode[NCH];

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         mq[c] = 0; mrest[c] = 0; mseed[c] = 0; msoc[c] = 0; mmode[c] = 0;
      end
   endtask

   task automatic model_ch(input int c, input int v, input int i);
      longint vc, socv, qn, seedq;
      vc = longint'(v) - (longint'(i) * 1000) / 1000;
      if (vc < 0) vc = 0;
      if (vc > 65535) vc = 65535;
      if (vc >= 65535)  socv = 100;
      else if (vc <= 0) socv = 0;
      else              socv = vc * 100 / 65535;
      qn = mq[c] + longint'(i) * 100;
      if (qn < 0) qn = 0;
      if (qn > Q_FULL) qn = Q_FULL;
      seedq = socv * Q_FULL / 100;
      if (!mseed[c]) begin
         mq[c] = seedq; mseed[c] = 1; mrest[c] = 0; msoc[c] = int'(socv); mmode[c] = 1;
      end else if (i > -5 && i < 5) begin
         if (mrest[c] < REST) begin
            mrest[c]++;
            if (mrest[c] == REST) begin
               mq[c] = seedq; msoc[c] = int'(socv); mmode[c] = 1;
            end
         end
      end else begin
         mrest[c] = 0; mq[c] = qn; msoc[c] = int'(qn * 100 / Q_FULL); mmode[c] = 0;
      end
   endtask

   // Drive one pass's inputs well clear of its snapshot and queue the result.
   task automatic do_pass(input int k, input int v0, input int i0, input int v1, input int i1);
      exp_t e;
      if (k > 0) while (cyc != CLK_DIV*k + 10) @(negedge clk);
      voltage[0 +: 16]  = 16'(v0);
      current[0 +: 16]  = 16'(i0);
      voltage[16 +: 16] = 16'(v1);
      current[16 +: 16] = 16'(i1);
      model_ch(0, v0, i0);
      model_ch(1, v1, i1);
      for (int c = 0; c < NCH; c++) begin
         e.soc[c*8 +: 8] = 8'(msoc[c]);
         e.mode[c]       = mmode[c];
      end
      e.cyc = CLK_DIV - 1 + LAT + CLK_DIV*k;
      sb.push_back(e);
   endtask

   function automatic int rnd_i();
      if ($urandom_range(0, 9) < 4) return int'($urandom_range(0, 12)) - 6;
      return int'($urandom_range(0, 600)) - 300;
   endfunction

   // Monitor: busy window every cycle, scoreboard compare on soc_valid.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", busy, (cyc >= CLK_DIV && (cyc % CLK_DIV) <= LAT - 1) ? 1 : 0);
         if (soc_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: soc_valid=1 at cycle %0d, required 0", cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("valid_cycle", cyc, e.cyc);
               for (int c = 0; c < NCH; c++) begin
                  check($sformatf("soc[%0d]", c), soc[c*8 +: 8], e.soc[c*8 +: 8]);
                  check($sformatf("mode[%0d]", c), soc_mode[c], e.mode[c]);
               end
            end
         end
      end
   end

   localparam int NDIR = 10;
   int dir_tab[NDIR][4] = '{
      '{32768,   0,  6554,   0},
      '{32768,  20,  6554, -50},
      '{32768,  20,  6554, -50},
      '{32768,  20,  6554,  90},
      '{32768,  20, 16384,   0},
      '{32768, -10, 16384,   6},
      '{16384,   0, 16384,   0},
      '{16384,   0, 16384,   0},
      '{16384,   0, 16384,   0},
      '{65535,   4,     0,  -4}
   };

   initial begin
      int npass;
      int n;
      npass = 40;
      model_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_soc", soc, 0);
      check("rst_mode", soc_mode, 0);
      check("rst_valid", soc_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_overrun_fast", overrun2, 0);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      for (int k = 0; k < npass; k++) begin
         if (k < NDIR)
            do_pass(k, dir_tab[k][0], dir_tab[k][1], dir_tab[k][2], dir_tab[k][3]);
         else
            do_pass(k, int'($urandom_range(0, 65535)), rnd_i(),
                       int'($urandom_range(0, 65535)), rnd_i());
      end

      // Abandon the next pass during CALC of channel 0.
      while (cyc != CLK_DIV*npass + 22) @(negedge clk);
      check("overrun_fast", overrun2, 1);
      check("overrun_main", overrun, 0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_soc", soc, 0);
      check("midrst_mode", soc_mode, 0);
      check("midrst_valid", soc_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_overrun_fast", overrun2, 0);
      model_reset();
      rst_n = 1'b1;
      do_pass(0, 32700, -100, int'($urandom_range(0, 65535)), rnd_i());
      do_pass(1, int'($urandom_range(0, 65535)), rnd_i(), int'($urandom_range(0, 65535)), rnd_i());

      n = 0;
      while (sb.size() != 0 && n < 4*CLK_DIV) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d passes outstanding, required 0", sb.size());
      end
      check("final_overrun", overrun, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/soc_estimator_mc.md
Name: soc_estimator_mc

Overview:
- Multi-channel successor to the single-cell hybrid SoC estimator.
- Tracks NUM_CH cells with one time-multiplexed datapath, sequenced by an FSM on each 1 ms tick.
- Each tick: ESR-compensated voltage SoC and clamped coulomb counting per channel.
- Recalibrates from voltage only after a programmable rest dwell; seeds every channel from voltage on its first pass after reset.
- Sits between the ADC front-end and the pack supervisor.

Parameters:
- NUM_CH, 4: number of cells.
- V_W, 16: voltage sample width (unsigned).
- I_W, 16: current sample width (signed, 0.1 A LSB, positive = charging).
- SOC_W, 8: SoC output width, percent.
- Q_W, 32: accumulator width (signed).
- CLK_DIV, 50000: clocks per tick; must exceed 3*NUM_CH+2.
- V_MAX, 65535: voltage code mapping to 100%.
- V_MIN, 0: voltage code mapping to 0%.
- Q_FULL, 1400000: accumulator value for 100%.
- I_SCALE, 100: accumulator units per current LSB per tick.
- ESR, 1000: ESR numerator.
- ESR_DIV, 1000: ESR denominator.
- I_THRESH, 5: rest threshold, current LSBs.
- REST_TICKS, 1000: consecutive resting ticks before voltage recalibration.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- voltage  in  NUM_CH*V_W  per-channel voltage; ch k at [k*V_W +: V_W].
- current  in  NUM_CH*I_W  per-channel signed current; same packing.
- soc  out  NUM_CH*SOC_W  per-channel SoC, 0..100.
- soc_mode  out  NUM_CH  1 = channel's last update came from voltage.
- soc_valid  out  1  one-cycle pulse when a full pass completes.
- busy  out  1  high while the FSM is not in IDLE.
- overrun  out  1  sticky; set when a tick arrives while busy; cleared only by reset.

Behaviour:
- Reset:
  - Synchronous, active-low: all registers clear on the clk edge with rst_n=0.
  - soc=0, soc_mode=0, soc_valid=0, busy=0, overrun=0.
  - Accumulators=0, rest counters=0, seeded flags=0, tick divider=0, FSM=IDLE.
  - Reset mid-pass abandons the pass; no soc_valid is produced.
- Tick: divider counts 0..CLK_DIV-1; tick is asserted in the cycle the count equals CLK_DIV-1.
- FSM states: IDLE, SNAP, then per channel LOAD, CALC, UPDATE, then DONE.
  - IDLE -> SNAP on tick. SNAP registers all voltage and current inputs atomically; later input changes do not affect the pass.
  - Channel index ch runs 0..NUM_CH-1: LOAD -> CALC -> UPDATE -> LOAD(ch+1), or DONE after the last channel.
  - DONE: soc_valid=1 for exactly one cycle, then IDLE.
  - soc_valid is asserted 3*NUM_CH+2 cycles after the tick cycle; busy is high over the same interval.
  - A tick while busy is ignored and sets overrun.
- LOAD:
  - v_comp = voltage - (current*ESR)/ESR_DIV, signed arithmetic, division truncates toward zero.
  - Saturate v_comp to [0, 2^V_W-1].
  - resting = (current > -I_THRESH) && (current < I_THRESH).
- CALC:
  - soc_v = 100 if v_comp >= V_MAX; 0 if v_comp <= V_MIN; otherwise floor((v_comp-V_MIN)*100/(V_MAX-V_MIN)).
  - q_next = q + current*I_SCALE, sign-extended to Q_W; saturate to [0, Q_FULL] with no wrap.
- UPDATE, in priority order:
  1. Not seeded: q = floor(soc_v*Q_FULL/100); seeded=1; rest_cnt=0; soc=soc_v; mode=1.
  2. Resting: rest_cnt saturates at REST_TICKS. When the incremented count equals REST_TICKS, q reloads as in case 1, soc=soc_v, mode=1. Otherwise q and soc hold and mode holds.
  3. Not resting: rest_cnt=0; q=q_next; soc=floor(q_next*100/Q_FULL); mode=0.
- soc and soc_mode change only in UPDATE of the relevant channel; they are stable at soc_valid and until the next UPDATE of that channel.

Test Plan:
- Bench parameters unless stated: NUM_CH=2, CLK_DIV=20, Q_FULL=10000, REST_TICKS=3.
- Seed: reset, ch0 V=32768 I=0 -> after first tick soc[0]=50, mode[0]=1; soc_valid exactly 8 cycles after the tick cycle.
- Charge clamp: seeded at 50 (q=5000), I=+20 -> ticks give soc 70, 90, 100, 100; mode=0; q never exceeds 10000.
- Discharge clamp: seeded at 10 (q=1000), I=-50 -> soc=0 after one tick, stays 0, no wrap.
- Rest dwell: after charging to 90, I=0 and V=16384 -> soc stays 90 for resting ticks 1-2; at tick 3 soc=25 and mode=1. An I=+6 pulse at tick 2 restarts the dwell.
- ESR: first pass with V=32700, I=-100 -> v_comp=32800, soc=50 (an uncompensated result of 49 is a failure).
- Overrun/reset: CLK_DIV=5, NUM_CH=2 -> overrun=1. Separately, rst_n low during CALC -> all outputs 0, no soc_valid; after release the first pass re-seeds.
